// File: rtl/display_pkg.sv
// Shared constants, FSM encoding and frame builder for the 7-segment display SPI link.
package display_pkg;

    localparam logic [3:0] DISPLAY_CMD_WRITE = 4'b0001;
    localparam int         BYTE_WIDTH        = 8;
    localparam int         FRAME_BITS        = 16;
    localparam int         ENTRY_WIDTH       = 4 + BYTE_WIDTH;

    localparam logic [3:0] ENABLE_REG        = 4'd0;
    localparam logic [3:0] DIGIT_REG_FIRST   = 4'd1;
    localparam logic [3:0] DIGIT_REG_LAST    = 4'd8;
    localparam logic [3:0] RADIX_REG         = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } spi_state_e;

    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [3:0] addr,
                                                          input logic [BYTE_WIDTH-1:0] value);
        return {DISPLAY_CMD_WRITE, addr, value};
    endfunction

endpackage

// File: rtl/display_cmd_fifo.sv
// Small register-based request FIFO; read data is valid in the same cycle as pop.
module display_cmd_fifo
    import display_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_WIDTH
) (
    input  logic                     block_clk_i,
    input  logic                     rst_low_i,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   level_reg;
    logic [WIDTH-1:0] entries [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (level_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (level_reg == '0);
    assign level   = level_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Each entry owns its own storage register, written only when the write pointer selects it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] data_reg;
            always_ff @(posedge block_clk_i) begin
                if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
                    data_reg <= push_data;
                end
            end
            assign entries[gi] = data_reg;
        end
    endgenerate

    assign pop_data = entries[rd_ptr_reg];

    always_ff @(posedge block_clk_i or negedge rst_low_i) begin
        if (!rst_low_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + (PTR_W+1)'(1);
                2'b01:   level_reg <= level_reg - (PTR_W+1)'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/display_spi_master.sv
// SPI master feeding the 7-segment display slave: queues register writes and sends
// each as a 16-bit MSB-first frame with sclk idle high and a guaranteed ss-high gap.
module display_spi_master
    import display_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic                  block_clk_i,
    input  logic                  rst_low_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [3:0]            wr_addr_i,
    input  logic [BYTE_WIDTH-1:0] wr_data_i,
    output logic                  busy_o,
    output logic                  spi_sclk_o,
    output logic                  spi_ss_o,
    output logic                  spi_mosi_o
);

    localparam int PHASE_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int PHASE_W   = $clog2(PHASE_MAX);
    localparam logic [PHASE_W-1:0] DIV_LOAD = PHASE_W'(CLK_DIV - 1);
    localparam logic [PHASE_W-1:0] GAP_LOAD = PHASE_W'(GAP_CYCLES - 1);

    spi_state_e            state_reg,   state_next;
    logic [PHASE_W-1:0]    phase_reg,   phase_next;
    logic [3:0]            bit_idx_reg, bit_idx_next;
    logic [FRAME_BITS-1:0] shifter_reg, shifter_next;
    logic                  sclk_reg,    sclk_next;
    logic                  ss_reg,      ss_next;
    logic                  mosi_reg,    mosi_next;

    logic                         fifo_pop;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]  fifo_level;
    logic [ENTRY_WIDTH-1:0]       fifo_dout;
    logic                         phase_done;

    display_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_WIDTH)
    ) u_fifo (
        .block_clk_i (block_clk_i),
        .rst_low_i   (rst_low_i),
        .push        (wr_valid_i),
        .push_data   ({wr_addr_i, wr_data_i}),
        .pop         (fifo_pop),
        .pop_data    (fifo_dout),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .level       (fifo_level)
    );

    assign wr_ready_o = !fifo_full;
    assign busy_o     = (state_reg != ST_IDLE) || (fifo_level != '0);
    assign phase_done = (phase_reg == '0);
    assign spi_sclk_o = sclk_reg;
    assign spi_ss_o   = ss_reg;
    assign spi_mosi_o = mosi_reg;

    always_ff @(posedge block_clk_i or negedge rst_low_i) begin
        if (!rst_low_i) begin
            state_reg   <= ST_IDLE;
            phase_reg   <= '0;
            bit_idx_reg <= '0;
            shifter_reg <= '1;
            sclk_reg    <= 1'b1;
            ss_reg      <= 1'b1;
            mosi_reg    <= 1'b1;
        end else begin
            state_reg   <= state_next;
            phase_reg   <= phase_next;
            bit_idx_reg <= bit_idx_next;
            shifter_reg <= shifter_next;
            sclk_reg    <= sclk_next;
            ss_reg      <= ss_next;
            mosi_reg    <= mosi_next;
        end
    end

    // Phase counter reloads on every state entry and counts down to zero.
    always_comb begin
        state_next   = state_reg;
        phase_next   = phase_reg;
        bit_idx_next = bit_idx_reg;
        shifter_next = shifter_reg;
        fifo_pop     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    shifter_next = build_frame(fifo_dout[ENTRY_WIDTH-1 -: 4],
                                               fifo_dout[BYTE_WIDTH-1:0]);
                    bit_idx_next = 4'(FRAME_BITS - 1);
                    phase_next   = DIV_LOAD;
                    state_next   = ST_SETUP;
                end
            end
            ST_SETUP, ST_LOW: begin
                if (phase_done) begin
                    phase_next = DIV_LOAD;
                    state_next = (state_reg == ST_SETUP) ? ST_LOW : ST_HIGH;
                end else begin
                    phase_next = phase_reg - PHASE_W'(1);
                end
            end
            ST_HIGH: begin
                if (phase_done) begin
                    phase_next = DIV_LOAD;
                    if (bit_idx_reg == 4'd0) begin
                        state_next = ST_HOLD;
                    end else begin
                        bit_idx_next = bit_idx_reg - 4'd1;
                        shifter_next = {shifter_reg[FRAME_BITS-2:0], 1'b1};
                        state_next   = ST_LOW;
                    end
                end else begin
                    phase_next = phase_reg - PHASE_W'(1);
                end
            end
            ST_HOLD: begin
                if (phase_done) begin
                    phase_next = GAP_LOAD;
                    state_next = ST_GAP;
                end else begin
                    phase_next = phase_reg - PHASE_W'(1);
                end
            end
            ST_GAP: begin
                if (phase_done) begin
                    phase_next = '0;
                    state_next = ST_IDLE;
                end else begin
                    phase_next = phase_reg - PHASE_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Pins follow the state one cycle later, so mosi and the sclk fall move together.
    always_comb begin
        ss_next   = (state_reg == ST_IDLE) || (state_reg == ST_GAP);
        sclk_next = (state_reg != ST_LOW);
        mosi_next = ss_next | shifter_reg[FRAME_BITS-1];
    end

endmodule

// File: tb/tb_display_spi_master.sv
// Randomised scoreboard bench for display_spi_master with a bus-level slave model.
module tb_display_spi_master;
    import display_pkg::*;

    localparam int CD0 = 4, GAP0 = 8, CD1 = 2, GAP1 = 2;

    logic       clk = 1'b0;
    logic       rst_low = 1'b0;
    logic       valid = 1'b0;
    logic [3:0] addr = 4'd0;
    logic [7:0] data = 8'd0;
    bit         sel = 1'b0;

    logic valid0, valid1, ready0, ready1, busy0, busy1;
    logic sclk0, sclk1, ss0, ss1, mosi0, mosi1;
    logic sclk_m, ss_m, mosi_m, busy_m, ready_m;
    int   cd_m, gap_m;

    assign valid0  = valid && !sel;
    assign valid1  = valid && sel;
    assign sclk_m  = sel ? sclk1  : sclk0;
    assign ss_m    = sel ? ss1    : ss0;
    assign mosi_m  = sel ? mosi1  : mosi0;
    assign busy_m  = sel ? busy1  : busy0;
    assign ready_m = sel ? ready1 : ready0;
    assign cd_m    = sel ? CD1  : CD0;
    assign gap_m   = sel ? GAP1 : GAP0;

    display_spi_master #(.CLK_DIV(CD0), .FIFO_DEPTH(4), .GAP_CYCLES(GAP0)) dut0 (
        .block_clk_i(clk), .rst_low_i(rst_low), .wr_valid_i(valid0), .wr_ready_o(ready0),
        .wr_addr_i(addr), .wr_data_i(data), .busy_o(busy0),
        .spi_sclk_o(sclk0), .spi_ss_o(ss0), .spi_mosi_o(mosi0));

    display_spi_master #(.CLK_DIV(CD1), .FIFO_DEPTH(4), .GAP_CYCLES(GAP1)) dut1 (
        .block_clk_i(clk), .rst_low_i(rst_low), .wr_valid_i(valid1), .wr_ready_o(ready1),
        .wr_addr_i(addr), .wr_data_i(data), .busy_o(busy1),
        .spi_sclk_o(sclk1), .spi_ss_o(ss1), .spi_mosi_o(mosi1));

    int checks = 0, failures = 0, cyc = 0;
    logic [15:0] exp_q[$];
    int          gap_q[$];
    logic [7:0]  exp_regs [10];
    logic [7:0]  slave_regs [10];

    bit          in_frame = 0, have_prev = 0, prev_ss = 1, prev_sclk = 1, prev_busy = 0;
    bit          idle_win = 0;
    logic [15:0] bits = '0, last_frame = '0;
    int cur_edges = 0, low_cnt = 0, high_cnt = 0, spacing_err = 0, last_rise = -1;
    int fall_cyc = 0, busy_fall_cyc = 0, idle_viol = 0, stray_edges = 0, frames_seen = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: plays the slave, samples mid-cycle, and checks every frame against the queue.
    always @(negedge clk) begin
        if (!rst_low) begin
            in_frame = 0; have_prev = 0; prev_ss = 1; prev_sclk = 1; prev_busy = 0;
            high_cnt = 0; cur_edges = 0;
            for (int i = 0; i < 10; i++) slave_regs[i] = 8'h00;
        end else begin
            if (!prev_ss && ss_m && in_frame) begin
                logic [15:0] e;
                frames_seen++;
                last_frame = bits;
                $display("frame %0d dut%0d: 0x%h edges=%0d ss_low=%0d cycle=%0d",
                         frames_seen, sel, bits, cur_edges, low_cnt, cyc);
                if (exp_q.size() == 0) begin
                    chk("frame_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_value", bits, e);
                end
                chk("frame_edges", cur_edges, 16);
                chk("ss_low_cycles", low_cnt, 34 * cd_m);
                chk("sclk_period", spacing_err, 0);
                if (bits[15:12] == DISPLAY_CMD_WRITE && bits[11:8] <= RADIX_REG)
                    slave_regs[bits[11:8]] = bits[7:0];
                in_frame = 0; have_prev = 1; high_cnt = 0;
            end
            if (prev_ss && !ss_m) begin
                if (have_prev) gap_q.push_back(high_cnt);
                in_frame = 1; bits = '0; cur_edges = 0; low_cnt = 0;
                spacing_err = 0; last_rise = -1; fall_cyc = cyc;
            end
            if (!ss_m) begin
                low_cnt++;
                if (!prev_sclk && sclk_m) begin
                    if (last_rise >= 0 && (cyc - last_rise) != 2 * cd_m) spacing_err++;
                    last_rise = cyc;
                    cur_edges++;
                    bits = {bits[14:0], mosi_m};
                end
            end else begin
                high_cnt++;
                if (prev_ss && !prev_sclk && sclk_m) stray_edges++;
            end
            if (prev_busy && !busy_m) busy_fall_cyc = cyc;
            if (idle_win && (sclk_m !== 1'b1 || ss_m !== 1'b1 || mosi_m !== 1'b1 || busy_m !== 1'b0))
                idle_viol++;
            prev_ss = ss_m; prev_sclk = sclk_m; prev_busy = busy_m;
        end
    end

    task automatic send(input logic [3:0] a, input logic [7:0] d, output int acc);
        int w = 0;
        @(negedge clk);
        valid = 1'b1; addr = a; data = d;
        while (!ready_m && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (!ready_m) begin
            chk("accept_timeout", 1, 0);
            valid = 1'b0;
            acc = -1;
        end else begin
            acc = cyc + 1;
            exp_q.push_back(16'h1000 + 16'(a) * 256 + 16'(d));
            if (a <= 4'd9) exp_regs[a] = d;
            $display("write dut%0d addr=%0d data=0x%h accept_cycle=%0d", sel, a, d, acc);
            @(posedge clk);
            #1 valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy_m || !ss_m) && n < 3000) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("drain_timeout", (n >= 3000), 0);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 10; i++) chk(tag, slave_regs[i], exp_regs[i]);
    endtask

    task automatic random_writes(input int n, input int max_gap);
        int acc;
        for (int i = 0; i < n; i++) begin
            send(4'($urandom_range(0, 15)), 8'($urandom), acc);
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
        end
    endtask

    initial begin
        int acc, acc1, acc6, n, base;
        for (int i = 0; i < 10; i++) exp_regs[i] = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_sclk", sclk0, 1); chk("rst_ss", ss0, 1); chk("rst_mosi", mosi0, 1);
        chk("rst_ready", ready0, 1); chk("rst_busy", busy0, 0);
        #2 rst_low = 1'b1;

        // Single write: latency, frame content, busy release.
        send(4'd0, 8'hFF, acc);
        wait_drain();
        chk("ss_fall_latency", fall_cyc - acc, 2);
        chk("busy_fall_latency", busy_fall_cyc - acc, 34 * CD0 + GAP0 + 1);
        chk("single_frame", last_frame, 16'h10FF);

        // Burst of six: back-pressure and inter-frame gaps.
        gap_q.delete();
        send(4'd1, 8'h01, acc1);
        for (int i = 2; i <= 5; i++) send(4'(i), 8'(i), acc);
        @(negedge clk);
        chk("ready_full", ready_m, 0);
        send(4'd6, 8'h06, acc6);
        wait_drain();
        chk("sixth_accept_delay", acc6 - acc1, 34 * CD0 + GAP0 + 1 + 2);
        chk("gap_count", gap_q.size() >= 5, 1);
        while (gap_q.size() > 5) void'(gap_q.pop_front());
        while (gap_q.size() > 0) chk("burst_gap", gap_q.pop_front(), GAP0 + 1);

        // Reset after the seventh rising edge of a frame.
        send(4'($urandom_range(1, 8)), 8'($urandom), acc);
        n = 0;
        while (!(in_frame && cur_edges >= 7) && n < 1000) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("midframe_wait", (n >= 1000), 0);
        rst_low = 1'b0;
        #1;
        chk("mid_rst_sclk", sclk_m, 1); chk("mid_rst_ss", ss_m, 1); chk("mid_rst_mosi", mosi_m, 1);
        chk("mid_rst_ready", ready_m, 1); chk("mid_rst_busy", busy_m, 0);
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_regs[i] = 8'h00;
        repeat (2) @(negedge clk);
        #2 rst_low = 1'b1;
        send(4'd3, 8'h5A, acc);
        wait_drain();
        chk("post_reset_frame", last_frame, 16'h135A);

        // Register-level scoreboard through the slave model.
        for (int i = 1; i <= 8; i++) send(4'(i), 8'(i - 1), acc);
        send(4'd9, 8'hAA, acc);
        send(4'd0, 8'hFF, acc);
        send(4'd12, 8'h55, acc);
        wait_drain();
        chk("addr12_frame", last_frame, 16'h1C55);
        check_regs("slave_regs");

        random_writes(16, 3);
        wait_drain();
        check_regs("slave_regs_rand");

        // Fast instance: CLK_DIV=2, GAP_CYCLES=2.
        sel = 1'b1;
        gap_q.delete();
        random_writes(8, 0);
        wait_drain();
        chk("fast_gap_count", gap_q.size() >= 7, 1);
        while (gap_q.size() > 7) void'(gap_q.pop_front());
        while (gap_q.size() > 0) chk("fast_gap", gap_q.pop_front(), GAP1 + 1);
        check_regs("slave_regs_fast");

        // Long idle period with no requests.
        sel = 1'b0;
        repeat (5) @(negedge clk);
        base = idle_viol;
        idle_win = 1'b1;
        repeat (1000) @(negedge clk);
        idle_win = 1'b0;
        chk("idle_activity", idle_viol - base, 0);
        chk("stray_sclk_edges", stray_edges, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
